fft_frame_feeder: RTL and testbench
===================================

# fft_frame_feeder

Input-side controller for the 2048-point streaming FFT in the acquisition chain. Captures one frame of 10-bit ADC samples into an internal 2048-deep buffer, writes the transform configuration (direction, scaling schedule) into the FFT, pulses `start`, then answers the FFT's `xn_index` requests with buffered samples while `rfd` is high. Sits between the ADC sample stream and the FFT wrapper. Supports single-shot and continuous re-arm operation.

## Interface
- `N_LOG2`, 11, log2 of frame length (2048 points).
- `DATA_W`, 10, sample width.
- `XN_LAT`, 3, cycles from an `xn_index` value to its sample on `xn_re`; legal range 1..4.
- `OFFSET_BIN`, 1, 1 = ADC data is offset binary, MSB inverted to two's complement; 0 = passed unchanged.

- `clk`  in  1  system clock; everything is synchronous to its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `adc_data`  in  10  ADC sample.
- `adc_valid`  in  1  `adc_data` is valid this cycle.
- `arm`  in  1  one-cycle request to capture and transform one frame.
- `continuous`  in  1  re-arm automatically after each frame.
- `cfg_inv`  in  1  direction for the next frame (1 = forward); latched on `arm`.
- `cfg_scale`  in  12  scaling schedule; latched on `arm`.
- `rfd`  in  1  FFT is ready for data.
- `xn_index`  in  11  sample index requested by the FFT.
- `done`  in  1  FFT completion pulse.
- `start`  out  1  one-cycle start pulse to the FFT.
- `xn_re`  out  10  two's-complement sample to the FFT.
- `xn_im`  out  10  constant 0.
- `fwd_inv`, `fwd_inv_we`  out  1, 1  direction value and its write strobe.
- `scale_sch`, `scale_sch_we`  out  12, 1  scaling schedule and its write strobe.
- `frame_busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse when the FFT finishes a frame.
- `overrun`  out  1  sticky; set when `adc_valid` arrives in continuous mode outside CAPTURE.

## Operation
- States: IDLE, CAPTURE, CONFIG, START, LOAD, WAIT_DONE.
- IDLE:
  - On `arm`, latch `cfg_inv`/`cfg_scale`, clear `overrun` and the write counter, then go to CAPTURE.
  - `arm` is ignored in all other states.
- CAPTURE:
  - Each `adc_valid` cycle writes the converted sample to buf[wr_cnt] and increments wr_cnt.
  - The write at wr_cnt = 2047 moves the FSM to CONFIG. A frame is 2048 valid samples; gaps in `adc_valid` are allowed.
- CONFIG: exactly one cycle. `fwd_inv_we` = `scale_sch_we` = 1; `fwd_inv`/`scale_sch` show the latched values. Next state is START.
- START: `start` = 1 for one cycle, then WAIT_RFD behaviour inside LOAD. LOAD does nothing until `rfd` rises.
- LOAD:
  - Each cycle with `rfd` = 1, buf[`xn_index`] is read and delayed so that it appears on `xn_re` exactly `XN_LAT` cycles later.
  - When `rfd` falls after having been high, go to WAIT_DONE. The pipeline keeps draining the final `XN_LAT` samples.
- WAIT_DONE:
  - On `done`, pulse `frame_done`.
  - Then go to CAPTURE (counter cleared) if `continuous`, else to IDLE.
- Conversion: with `OFFSET_BIN` = 1, buf = {~adc_data[9], adc_data[8:0]} (0x000 becomes 0x200 = -512; 0x3FF becomes 0x1FF = +511).
- Overrun: `adc_valid` in CONFIG, START, LOAD or WAIT_DONE while `continuous` = 1 sets `overrun`. The sample is dropped and the buffer is not written.
- Reset mid-operation: returns to IDLE. The buffer contents are don't-care.

## Timing
- Reset values:
  - `start`, `fwd_inv_we`, `scale_sch_we`, `frame_busy`, `frame_done`, `overrun` = 0.
  - `xn_re`, `xn_im` = 0; `scale_sch` = 0; `fwd_inv` = 1.
  - Delay pipeline cleared.
- The cycle after the 2048th `adc_valid`: CONFIG, so the write strobes are high.
- The following cycle: `start` is high.
- `xn_re` for index k is valid exactly `XN_LAT` cycles after the `rfd`-qualified cycle carrying `xn_index` = k.
- `frame_done` is registered and goes high the cycle after `done` is sampled.
- `arm` and `done` arriving in the same cycle in IDLE: `arm` is taken; `done` is ignored.
- `frame_busy` rises the cycle after `arm` and falls the cycle after `frame_done` when not continuous.

## Test plan
- Ramp frame:
  - Stimulus: `arm`, then 2048 samples with adc_data = index[9:0]; FFT model requests `xn_index` 0..2047 while `rfd` is high.
  - Required: `xn_re` = index ^ 0x200, exactly 3 cycles after each index.
- Config pulses:
  - Stimulus: `cfg_inv` = 0, `cfg_scale` = 0xAAA at `arm`.
  - Required: one-cycle `fwd_inv_we`/`scale_sch_we` carrying 0/0xAAA the cycle after the last sample; `start` the following cycle; neither strobe fires again.
- Gapped capture:
  - Stimulus: `adc_valid` at 50% duty.
  - Required: CONFIG only after 2048 valid samples; no samples lost or duplicated.
- Continuous with overrun:
  - Stimulus: `continuous` = 1 and `adc_valid` held high.
  - Required: `overrun` = 1 after the first CONFIG; second frame captures again after `frame_done`; `overrun` clears only on a new `arm` from IDLE.
- Reset mid-LOAD:
  - Stimulus: `rst` at `xn_index` = 1000.
  - Required: all outputs at reset values the next cycle; a subsequent `arm` produces a correct full frame.
- `OFFSET_BIN` = 0:
  - Stimulus: adc_data 0x3FF.
  - Required: `xn_re` = 0x3FF.

Source files
------------

// File: rtl/fft_frame_feeder.sv
// Input-side controller for the streaming FFT: captures one ADC frame into a local buffer,
// programs direction/scaling, starts the transform and serves xn_index requests.
module fft_frame_feeder #(
    parameter int N_LOG2     = 11,
    parameter int DATA_W     = 10,
    parameter int XN_LAT     = 3,
    parameter int OFFSET_BIN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              arm,
    input  logic              continuous,
    input  logic              cfg_inv,
    input  logic [11:0]       cfg_scale,
    input  logic              rfd,
    input  logic [N_LOG2-1:0] xn_index,
    input  logic              done,
    output logic              start,
    output logic [DATA_W-1:0] xn_re,
    output logic [DATA_W-1:0] xn_im,
    output logic              fwd_inv,
    output logic              fwd_inv_we,
    output logic [11:0]       scale_sch,
    output logic              scale_sch_we,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam int                DEPTH    = 2 ** N_LOG2;
    localparam logic [N_LOG2-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        CONFIG,
        START,
        LOAD,
        WAIT_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [N_LOG2-1:0]  wr_cnt_q;
    logic               cfg_inv_q;
    logic [11:0]        cfg_scale_q;
    logic               overrun_q;
    logic               frame_done_q;
    logic               rfd_seen_q;

    logic               latch_cfg;
    logic               clr_cnt;
    logic               buf_we;
    logic               rd_en;
    logic               set_overrun;
    logic               done_pulse;

    logic [DATA_W-1:0]  adc_conv;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  pipe_q [XN_LAT];

    // Offset-binary to two's complement is just an MSB flip.
    assign adc_conv = (OFFSET_BIN != 0) ? {~adc_data[DATA_W-1], adc_data[DATA_W-2:0]}
                                        : adc_data;

    always_comb begin
        state_d      = state_q;
        latch_cfg    = 1'b0;
        clr_cnt      = 1'b0;
        buf_we       = 1'b0;
        rd_en        = 1'b0;
        set_overrun  = 1'b0;
        done_pulse   = 1'b0;
        start        = 1'b0;
        fwd_inv_we   = 1'b0;
        scale_sch_we = 1'b0;
        frame_busy   = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    latch_cfg = 1'b1;
                    clr_cnt   = 1'b1;
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
                if (adc_valid) begin
                    buf_we = 1'b1;
                    if (wr_cnt_q == LAST_IDX) begin
                        state_d = CONFIG;
                    end
                end
            end
            CONFIG: begin
                fwd_inv_we   = 1'b1;
                scale_sch_we = 1'b1;
                state_d      = START;
            end
            START: begin
                start   = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                rd_en = rfd;
                if (rfd_seen_q && !rfd) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // Leave one cycle after the frame_done pulse so busy outlasts it.
                if (frame_done_q) begin
                    state_d = continuous ? CAPTURE : IDLE;
                    clr_cnt = continuous;
                end else if (done) begin
                    done_pulse = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (continuous && adc_valid && (state_q inside {CONFIG, START, LOAD, WAIT_DONE})) begin
            set_overrun = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_cnt_q     <= '0;
            cfg_inv_q    <= 1'b1;
            cfg_scale_q  <= '0;
            overrun_q    <= 1'b0;
            frame_done_q <= 1'b0;
            rfd_seen_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= done_pulse;

            if (latch_cfg) begin
                cfg_inv_q   <= cfg_inv;
                cfg_scale_q <= cfg_scale;
            end

            if (clr_cnt) begin
                wr_cnt_q <= '0;
            end else if (buf_we) begin
                wr_cnt_q <= wr_cnt_q + N_LOG2'(1);
            end

            if (latch_cfg) begin
                overrun_q <= 1'b0;
            end else if (set_overrun) begin
                overrun_q <= 1'b1;
            end

            if (state_q == START) begin
                rfd_seen_q <= 1'b0;
            end else if (rd_en) begin
                rfd_seen_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            mem[wr_cnt_q] <= adc_conv;
        end
    end

    // Stage 0 is the buffer read register; the remaining stages pad to XN_LAT.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < XN_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            if (rd_en) begin
                pipe_q[0] <= mem[xn_index];
            end
            for (int i = 1; i < XN_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign xn_re      = pipe_q[XN_LAT-1];
    assign xn_im      = '0;
    assign fwd_inv    = cfg_inv_q;
    assign scale_sch  = cfg_scale_q;
    assign overrun    = overrun_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Scoreboard bench for fft_frame_feeder: random frames, a frame-level reference model,
// and a negedge monitor that checks xn_re and the one-cycle control pulses.
module tb_fft_frame_feeder;

    localparam int FRAME = 2048;
    localparam int LAT   = 3;

    typedef struct {
        int         due;
        logic [9:0] exp_a;
        logic [9:0] exp_b;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  adc_data;
    logic        adc_valid;
    logic        arm;
    logic        continuous;
    logic        cfg_inv;
    logic [11:0] cfg_scale;
    logic        rfd;
    logic [10:0] xn_index;
    logic        done;

    logic        start, fwd_inv, fwd_inv_we, scale_sch_we, frame_busy, frame_done, overrun;
    logic [9:0]  xn_re, xn_im;
    logic [11:0] scale_sch;

    logic        b_start, b_fwd_inv, b_fwd_inv_we, b_scale_sch_we, b_frame_busy;
    logic        b_frame_done, b_overrun;
    logic [9:0]  b_xn_re, b_xn_im;
    logic [11:0] b_scale_sch;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_cfg_cycle = -1;
    int          exp_start_cycle = -1;
    int          exp_fd_cycle = -1;
    logic        exp_inv;
    logic [11:0] exp_scale;
    logic        ovr_model = 1'b0;
    logic        bg_valid = 1'b0;
    logic [9:0]  frame_raw [FRAME];
    sb_item_t    sb [$];
    sb_item_t    mon_item;

    fft_frame_feeder #(.N_LOG2(11), .DATA_W(10), .XN_LAT(LAT), .OFFSET_BIN(1)) dut (
        .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid), .arm(arm),
        .continuous(continuous), .cfg_inv(cfg_inv), .cfg_scale(cfg_scale), .rfd(rfd),
        .xn_index(xn_index), .done(done), .start(start), .xn_re(xn_re), .xn_im(xn_im),
        .fwd_inv(fwd_inv), .fwd_inv_we(fwd_inv_we), .scale_sch(scale_sch),
        .scale_sch_we(scale_sch_we), .frame_busy(frame_busy), .frame_done(frame_done),
        .overrun(overrun)
    );

    fft_frame_feeder #(.N_LOG2(11), .DATA_W(10), .XN_LAT(LAT), .OFFSET_BIN(0)) dut_raw (
        .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid), .arm(arm),
        .continuous(continuous), .cfg_inv(cfg_inv), .cfg_scale(cfg_scale), .rfd(rfd),
        .xn_index(xn_index), .done(done), .start(b_start), .xn_re(b_xn_re), .xn_im(b_xn_im),
        .fwd_inv(b_fwd_inv), .fwd_inv_we(b_fwd_inv_we), .scale_sch(b_scale_sch),
        .scale_sch_we(b_scale_sch_we), .frame_busy(b_frame_busy), .frame_done(b_frame_done),
        .overrun(b_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        arm       = 1'b0;
        done      = 1'b0;
        adc_valid = bg_valid;
        adc_data  = 10'($urandom);
    endtask

    function automatic logic [9:0] edge_val(input int n);
        case (n)
            0:       return 10'h000;
            1:       return 10'h3FF;
            2:       return 10'h200;
            default: return 10'h1FF;
        endcase
    endfunction

    // Monitor: pops scheduled samples and checks the single-cycle strobes.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_item = sb.pop_front();
            if (mon_item.due < cyc) begin
                checkOutput("xn_re_late", 32'(cyc), 32'(mon_item.due));
            end else begin
                checkOutput("xn_re", 32'(xn_re), 32'(mon_item.exp_a));
                checkOutput("xn_re_raw", 32'(b_xn_re), 32'(mon_item.exp_b));
                checkOutput("xn_im", 32'(xn_im), 32'd0);
            end
        end
        if (fwd_inv_we || scale_sch_we || cyc == exp_cfg_cycle) begin
            checkOutput("fwd_inv_we", 32'(fwd_inv_we), 32'(cyc == exp_cfg_cycle));
            checkOutput("scale_sch_we", 32'(scale_sch_we), 32'(cyc == exp_cfg_cycle));
            if (cyc == exp_cfg_cycle) begin
                checkOutput("fwd_inv", 32'(fwd_inv), 32'(exp_inv));
                checkOutput("scale_sch", 32'(scale_sch), 32'(exp_scale));
            end
        end
        if (start || cyc == exp_start_cycle) begin
            checkOutput("start", 32'(start), 32'(cyc == exp_start_cycle));
        end
        if (frame_done || cyc == exp_fd_cycle) begin
            checkOutput("frame_done", 32'(frame_done), 32'(cyc == exp_fd_cycle));
        end
    end

    task automatic check_reset_values();
        checkOutput("rst_start", 32'(start), 32'd0);
        checkOutput("rst_fwd_inv_we", 32'(fwd_inv_we), 32'd0);
        checkOutput("rst_scale_sch_we", 32'(scale_sch_we), 32'd0);
        checkOutput("rst_frame_busy", 32'(frame_busy), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_xn_re", 32'(xn_re), 32'd0);
        checkOutput("rst_xn_im", 32'(xn_im), 32'd0);
        checkOutput("rst_scale_sch", 32'(scale_sch), 32'd0);
        checkOutput("rst_fwd_inv", 32'(fwd_inv), 32'd1);
        checkOutput("rst_raw_xn_re", 32'(b_xn_re), 32'd0);
    endtask

    task automatic do_arm(input logic inv, input logic [11:0] scale, input logic with_done);
        tick();
        arm       = 1'b1;
        cfg_inv   = inv;
        cfg_scale = scale;
        done      = with_done;
        exp_inv   = inv;
        exp_scale = scale;
        tick();
        adc_valid = 1'b0;
        ovr_model = 1'b0;
        checkOutput("busy_after_arm", 32'(frame_busy), 32'd1);
        checkOutput("overrun_after_arm", 32'(overrun), 32'(ovr_model));
    endtask

    // Drives exactly FRAME valid samples (with random gaps) and records them in the model.
    task automatic applyStimulus(input int duty, input logic ramp, input logic edges);
        int n = 0;
        while (n < FRAME) begin
            tick();
            if (int'($urandom_range(0, 99)) < duty) begin
                adc_valid = 1'b1;
                if (ramp) adc_data = n[9:0];
                else if (edges && n < 4) adc_data = edge_val(n);
                frame_raw[n] = adc_data;
                n++;
            end else begin
                adc_valid = 1'b0;
            end
        end
        exp_cfg_cycle   = cyc + 1;
        exp_start_cycle = cyc + 2;
    endtask

    // FFT model: waits for start, then requests FRAME indices with rfd held high.
    task automatic serve_fft(input logic ramp_order, input int abort_at, input logic arm_glitch);
        int       waited = 0;
        int       idx;
        sb_item_t it;
        do begin
            tick();
            waited++;
        end while (start !== 1'b1 && waited < 16);
        if (start !== 1'b1) begin
            checkOutput("start_timeout", 32'(start), 32'd1);
            return;
        end
        if (continuous && bg_valid) ovr_model = 1'b1;
        checkOutput("overrun_at_start", 32'(overrun), 32'(ovr_model));
        repeat ($urandom_range(1, 4)) tick();
        for (int k = 0; k < FRAME; k++) begin
            tick();
            idx      = ramp_order ? k : int'($urandom_range(0, FRAME - 1));
            rfd      = 1'b1;
            xn_index = 11'(idx);
            if (k == abort_at) begin
                rst = 1'b1;
                while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
                return;
            end
            if (arm_glitch && k == FRAME / 4) begin
                arm       = 1'b1;
                cfg_inv   = ~exp_inv;
                cfg_scale = ~exp_scale;
            end
            it.due   = cyc + LAT;
            it.exp_a = frame_raw[idx] ^ 10'h200;
            it.exp_b = frame_raw[idx];
            sb.push_back(it);
        end
        tick();
        rfd = 1'b0;
    endtask

    task automatic finish_frame();
        repeat ($urandom_range(4, 8)) tick();
        tick();
        done         = 1'b1;
        exp_fd_cycle = cyc + 1;
        tick();
        checkOutput("busy_during_frame_done", 32'(frame_busy), 32'd1);
        if (!continuous) begin
            tick();
            checkOutput("busy_after_frame_done", 32'(frame_busy), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; adc_data = '0; adc_valid = 1'b0; arm = 1'b0; continuous = 1'b0;
        cfg_inv = 1'b1; cfg_scale = '0; rfd = 1'b0; xn_index = '0; done = 1'b0;
        exp_inv = 1'b1; exp_scale = '0;
        repeat (3) tick();
        check_reset_values();
        rst = 1'b0;

        // Ramp frame with config 0/0xAAA; done coincident with arm must be ignored.
        do_arm(1'b0, 12'hAAA, 1'b1);
        applyStimulus(100, 1'b1, 1'b0);
        serve_fft(1'b1, -1, 1'b0);
        finish_frame();

        // Gapped capture with stray valids outside CAPTURE in single-shot mode.
        bg_valid = 1'b1;
        do_arm(1'b1, 12'($urandom), 1'b0);
        applyStimulus(50, 1'b0, 1'b0);
        serve_fft(1'b0, -1, 1'b0);
        finish_frame();
        checkOutput("overrun_single_shot", 32'(overrun), 32'(ovr_model));

        // Continuous mode with valid held high; arm during LOAD must not relatch.
        continuous = 1'b1;
        do_arm(1'($urandom), 12'($urandom), 1'b0);
        applyStimulus(100, 1'b0, 1'b0);
        serve_fft(1'b0, -1, 1'b1);
        finish_frame();
        checkOutput("overrun_continuous", 32'(overrun), 32'd1);
        applyStimulus(100, 1'b0, 1'b0);
        serve_fft(1'b0, -1, 1'b0);
        continuous = 1'b0;
        finish_frame();
        checkOutput("overrun_sticky_idle", 32'(overrun), 32'(ovr_model));

        // Reset in the middle of LOAD, then a clean frame with extreme samples.
        bg_valid = 1'b0;
        do_arm(1'b1, 12'($urandom), 1'b0);
        applyStimulus(100, 1'b0, 1'b0);
        serve_fft(1'b1, 1000, 1'b0);
        tick();
        check_reset_values();
        rst = 1'b0;
        rfd = 1'b0;
        ovr_model = 1'b0;
        do_arm(1'($urandom), 12'($urandom), 1'b0);
        applyStimulus(70, 1'b0, 1'b1);
        serve_fft(1'b0, -1, 1'b0);
        finish_frame();

        repeat (LAT + 2) tick();
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got time limit at cycle %0d, expected completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
